// File: rtl/uart_alu_pkg.sv
// Shared tags and scheduler state encoding for the UART ALU link.
package uart_alu_pkg;

    localparam logic [1:0] OPERAND1_TAG = 2'b00;
    localparam logic [1:0] OPERAND2_TAG = 2'b01;
    localparam logic [1:0] OPCODE_TAG   = 2'b10;
    localparam logic [1:0] RESP_TAG     = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_HDR = 3'd1,
        WAIT_HDR = 3'd2,
        SEND_RES = 3'd3,
        WAIT_RES = 3'd4
    } sched_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding {opcode,result} entries for the TX scheduler.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_tx_scheduler.sv
// Queues ALU results and sends each as a header+result byte frame
// over the shared UART transmitter using its start/done handshake.
module alu_result_tx_scheduler
    import uart_alu_pkg::*;
#(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 8,
    parameter int DEPTH   = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_data_ready,
    input  logic [NB_OP-1:0]   i_opcode,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_overflow,
    output logic               o_busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WIDTH = NB_OP + NB_DATA;
    localparam logic [AW:0] ONE = (AW+1)'(1);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic               start_nxt;
    logic [NB_DATA-1:0] data_nxt;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic [WIDTH-1:0]   rdata;
    logic [NB_OP-1:0]   head_op;
    logic [NB_DATA-1:0] head_res;

    assign {head_op, head_res} = rdata;

    // The head entry is only released once its result byte is on the wire.
    assign pop  = (state == WAIT_RES) && i_tx_done;
    assign push = i_data_ready && (!full || pop);

    assign o_busy = !empty || (state != IDLE);

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (push),
        .pop   (pop),
        .wdata ({i_opcode, i_alu_result}),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_tx_start <= start_nxt;
            o_tx_data  <= data_nxt;
            if (i_data_ready && full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        data_nxt  = o_tx_data;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = SEND_HDR;
                end
            end
            SEND_HDR: begin
                data_nxt = {RESP_TAG, head_op};
                if (!i_tx_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (i_tx_done) begin
                    state_nxt = SEND_RES;
                end
            end
            SEND_RES: begin
                data_nxt = head_res;
                if (!i_tx_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // A push landing with the pop keeps a last entry alive.
                if (i_tx_done) begin
                    if (count > ONE || i_data_ready) begin
                        state_nxt = SEND_HDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_tx_scheduler.sv
// Randomized bench for alu_result_tx_scheduler with a queue-level reference model.
module tb_alu_result_tx_scheduler;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       data_ready;
    logic [5:0] opcode;
    logic [7:0] alu_result;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       overflow;
    logic       busy;

    logic       model_busy;
    logic       force_busy;
    logic       uart_en;
    int         cnt;

    int n_chk;
    int n_pass;
    int start_cnt;

    typedef struct {
        logic [5:0] op;
        logic [7:0] res;
    } ent_t;

    ent_t mq[$];
    logic hdr_next;
    logic res_out;
    logic exp_ovf;
    logic prev_start;
    logic prev_busy;

    assign tx_busy = model_busy | force_busy;

    alu_result_tx_scheduler #(
        .NB_OP   (6),
        .NB_DATA (8),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_data_ready (data_ready),
        .i_opcode     (opcode),
        .i_alu_result (alu_result),
        .i_tx_busy    (tx_busy),
        .i_tx_done    (tx_done),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // UART model: done 10 cycles after start; done held back while !uart_en.
    initial begin
        model_busy = 1'b0;
        tx_done    = 1'b0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (rst) begin
                model_busy = 1'b0;
                cnt        = 0;
            end else if (model_busy) begin
                if (cnt == 0) begin
                    if (uart_en) begin
                        tx_done    = 1'b1;
                        model_busy = 1'b0;
                    end
                end else begin
                    cnt--;
                end
            end else if (tx_start) begin
                model_busy = 1'b1;
                cnt        = 9;
            end
        end
    end

    // Reference model: a queue of results, head released on result-byte done.
    initial begin
        hdr_next   = 1'b1;
        res_out    = 1'b0;
        exp_ovf    = 1'b0;
        prev_start = 1'b0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                hdr_next   = 1'b1;
                res_out    = 1'b0;
                exp_ovf    = 1'b0;
                prev_start = 1'b0;
                prev_busy  = 1'b0;
                continue;
            end
            if (tx_start) begin
                logic [7:0] e;
                start_cnt++;
                chk("start_while_busy", {31'd0, prev_busy}, 0);
                chk("start_b2b", {31'd0, prev_start}, 0);
                if (mq.size() == 0) begin
                    chk("start_empty", 1, 0);
                end else begin
                    e = hdr_next ? {2'b11, mq[0].op} : mq[0].res;
                    chk(hdr_next ? "hdr_byte" : "res_byte", {24'd0, tx_data},
                        {24'd0, e});
                    if (!hdr_next) begin
                        res_out = 1'b1;
                    end
                end
                hdr_next = !hdr_next;
            end
            if (tx_done && res_out) begin
                void'(mq.pop_front());
                res_out = 1'b0;
            end
            if (data_ready) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back('{op: opcode, res: alu_result});
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            prev_start = tx_start;
            prev_busy  = tx_busy;
        end
    end

    task automatic push(input logic [5:0] op, input logic [7:0] res);
        data_ready = 1'b1;
        opcode     = op;
        alu_result = res;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && !tx_busy && !tx_done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, ok}, 1);
    endtask

    task automatic wait_starts(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 500 && seen < n; i++) begin
            @(posedge clk);
            #2;
            if (tx_start) begin
                seen++;
            end
        end
        chk("start_wait", seen, n);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [5:0] op;
        n_chk      = 0;
        n_pass     = 0;
        start_cnt  = 0;
        rst        = 1'b1;
        data_ready = 1'b0;
        opcode     = '0;
        alu_result = '0;
        force_busy = 1'b0;
        uart_en    = 1'b1;

        #1;
        chk("rst_start", {31'd0, tx_start}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single frame, latency and header value
        s = start_cnt;
        push(6'h20, 8'h0F);
        @(posedge clk);
        #1;
        chk("lat_early", {31'd0, tx_start}, 0);
        @(posedge clk);
        #1;
        chk("lat_start", {31'd0, tx_start}, 1);
        chk("lat_hdr", {24'd0, tx_data}, 32'hE0);
        wait_idle();
        chk("s1_starts", start_cnt - s, 2);
        chk("s1_busy", {31'd0, busy}, 0);

        // three back-to-back pushes
        s = start_cnt;
        push(6'h22, 8'h01);
        push(6'h22, 8'h02);
        push(6'h22, 8'h03);
        wait_idle();
        chk("s2_starts", start_cnt - s, 6);
        chk("s2_ovf", {31'd0, overflow}, 0);

        // UART busy blocks the header start
        force_busy = 1'b1;
        op = 6'($urandom);
        s = start_cnt;
        push(op, 8'($urandom));
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("s3_nostart", start_cnt - s, 0);
        chk("s3_pre", {31'd0, tx_start}, 0);
        chk("s3_hdr", {24'd0, tx_data}, {24'd0, 2'b11, op});
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("s3_start", {31'd0, tx_start}, 1);
        wait_idle();

        // overflow with done withheld
        uart_en = 1'b0;
        s = start_cnt;
        repeat (5) push(6'($urandom), 8'($urandom));
        chk("s4_ovf", {31'd0, overflow}, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("s4_ovf_hold", {31'd0, overflow}, 1);
        uart_en = 1'b1;
        wait_idle();
        chk("s4_starts", start_cnt - s, 8);
        chk("s4_ovf_sticky", {31'd0, overflow}, 1);
        apply_reset();
        chk("s4_ovf_clr", {31'd0, overflow}, 0);

        // full queue, push coinciding with the result-byte done
        uart_en = 1'b0;
        s = start_cnt;
        repeat (4) push(6'($urandom), 8'($urandom));
        uart_en = 1'b1;
        wait_starts(1);
        uart_en = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        uart_en = 1'b1;
        @(posedge clk);
        #1;
        push(6'($urandom), 8'($urandom));
        chk("s5_ovf", {31'd0, overflow}, 0);
        wait_idle();
        chk("s5_starts", start_cnt - s, 10);
        chk("s5_ovf_end", {31'd0, overflow}, 0);

        // reset while waiting on the result byte
        uart_en = 1'b0;
        repeat (2) push(6'($urandom), 8'($urandom));
        repeat (3) @(posedge clk);
        #1;
        uart_en = 1'b1;
        wait_starts(1);
        uart_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_start", {31'd0, tx_start}, 0);
        chk("s6_data", {24'd0, tx_data}, 0);
        chk("s6_ovf", {31'd0, overflow}, 0);
        chk("s6_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        uart_en = 1'b1;
        s = start_cnt;
        repeat (50) @(posedge clk);
        #1;
        chk("s6_nostart", start_cnt - s, 0);
        chk("s6_idle", {31'd0, busy}, 0);

        // random traffic against the model
        repeat (80) begin
            data_ready = ($urandom_range(0, 3) == 0);
            opcode     = 6'($urandom);
            alu_result = 8'($urandom);
            @(posedge clk);
            #1;
        end
        data_ready = 1'b0;
        wait_idle();
        chk("rnd_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("rnd_drain", mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
